// File: rtl/sap_core_param.sv
// Parameterised SAP-1 style accumulator core: multi-cycle fetch/execute over a
// combinational single-port RAM, with A/B registers, carry/zero flags and an output register.
module sap_core_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_in_en,
    output logic [DATA_W-1:0] ram_data_out,
    output logic [ADDR_W-1:0] pc_disp,
    output logic [DATA_W-1:0] out_display,
    output logic              out_strobe,
    output logic              halted,
    output logic              carry,
    output logic              zero
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_E0,
        S_E1,
        S_E2,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic                strobe_q, strobe_d;
    logic                halted_q, halted_d;
    logic                ram_in_en_q, ram_in_en_d;

    logic [OP_W-1:0]     opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;

    // State register; reset wins over everything, including HALT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            strobe_q    <= 1'b0;
            halted_q    <= 1'b0;
            ram_in_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            strobe_q    <= strobe_d;
            halted_q    <= halted_d;
            ram_in_en_q <= ram_in_en_d;
        end
    end

    // Next-state and datapath; pulse outputs are decided one state early so they are registered
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        strobe_d    = 1'b0;
        halted_d    = 1'b0;
        ram_in_en_d = 1'b0;

        opcode  = ir_q[DATA_W-1 -: OP_W];
        operand = ir_q[ADDR_W-1:0];
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = a_q - b_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_F0;
            end
            S_F0: begin
                mar_d   = pc_q;
                state_d = S_F1;
            end
            S_F1: begin
                ir_d    = ram_data_in;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_E0;
            end
            S_E0: begin
                state_d = S_F0;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        mar_d   = operand;
                        state_d = S_E1;
                    end
                    OP_STA: begin
                        mar_d       = operand;
                        ram_in_en_d = 1'b1;
                        state_d     = S_E1;
                    end
                    OP_LDI: a_d = DATA_W'(operand);
                    OP_JMP: pc_d = operand;
                    OP_JC:  if (carry_q) pc_d = operand;
                    OP_JZ:  if (zero_q)  pc_d = operand;
                    OP_OUT: begin
                        out_d    = a_q;
                        strobe_d = 1'b1;
                    end
                    OP_HLT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_E1: begin
                state_d = S_F0;
                case (opcode)
                    OP_LDA: a_d = ram_data_in;
                    OP_ADD, OP_SUB: begin
                        b_d     = ram_data_in;
                        state_d = S_E2;
                    end
                    default: ;
                endcase
            end
            S_E2: begin
                state_d = S_F0;
                if (opcode == OP_SUB) begin
                    a_d     = diff;
                    carry_d = (a_q >= b_q);
                    zero_d  = (diff == '0);
                end else begin
                    a_d     = sum[DATA_W-1:0];
                    carry_d = sum[DATA_W];
                    zero_d  = (sum[DATA_W-1:0] == '0);
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ram_addr     = mar_q;
    assign ram_in_en    = ram_in_en_q;
    assign ram_data_out = a_q;
    assign pc_disp      = pc_q;
    assign out_display  = out_q;
    assign out_strobe   = strobe_q;
    assign halted       = halted_q;
    assign carry        = carry_q;
    assign zero         = zero_q;

endmodule
